// File: rtl/simple_dma_controller_pkg.sv
// Shared definitions for the simple DMA controller: FSM state encoding, transfer direction
// and write-enable constants, plus the next-word state selection.
package simple_dma_controller_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StWaitDev,
        StMemAcc,
        StMemData,
        StDevAck,
        StAckGap,
        StGap,
        StWaitRd,
        StDone,
        StErr
    } dma_state_e;

    localparam logic DirRd = 1'b1;
    localparam logic DirWr = 1'b0;

    localparam logic [1:0] WeWord = 2'b11;
    localparam logic [1:0] WeNone = 2'b00;

    // Reads wait for the device to be ready for the next word; writes wait for device data.
    function automatic dma_state_e next_word_state(input logic rd_wr, input logic dev_ack);
        if (rd_wr == DirRd) begin
            return dev_ack ? StMemAcc : StWaitRd;
        end
        return StWaitDev;
    endfunction

endpackage

// File: rtl/simple_dma_xfer_counter.sv
// Transfer bookkeeping: 15-bit word address incrementer (wraps 7FFF->0000) and
// 16-bit remaining-word down-counter with load, step and zero detect.
module simple_dma_xfer_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [14:0] addr_i,
    input  logic [15:0] cnt_i,
    output logic [14:0] addr_o,
    output logic [15:0] cnt_o,
    output logic        zero_o
);

    logic [14:0] addr_d, addr_q;
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = cnt_i;
        end else if (step_i) begin
            addr_d = addr_q + 15'd1;
            cnt_d  = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/simple_dma_controller.sv
// Responder end of a device<->DMA handshake: moves words between a peripheral and memory
// through an openMSP430-style dma_* master port, one transfer in flight at a time.
module simple_dma_controller
    import simple_dma_controller_pkg::*;
#(
    parameter logic        DMA_PRIORITY = 1'b0,
    parameter int unsigned WORD_GAP     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_error,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
);

    localparam logic [3:0] GapLast = 4'(WORD_GAP - 1);

    dma_state_e  state_d, state_q;
    logic        rd_wr_d, rd_wr_q;
    logic [15:0] dev_in_d, dev_in_q;
    logic [15:0] din_d, din_q;
    logic [3:0]  gap_d, gap_q;
    logic        cnt_load, cnt_step, cnt_zero;
    logic [15:0] cnt_unused;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = dma_start_address[0];

    simple_dma_xfer_counter u_xfer_counter (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (cnt_load),
        .step_i (cnt_step),
        .addr_i (dma_start_address[15:1]),
        .cnt_i  (dma_num_words),
        .addr_o (dma_addr),
        .cnt_o  (cnt_unused),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        rd_wr_d  = rd_wr_q;
        dev_in_d = dev_in_q;
        din_d    = din_q;
        gap_d    = gap_q;
        cnt_load = 1'b0;
        cnt_step = 1'b0;

        case (state_q)
            StIdle: begin
                if (dma_rqst) begin
                    rd_wr_d  = dma_rd_wr;
                    cnt_load = 1'b1;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (!dma_rqst)              state_d = StIdle;
                else if (cnt_zero)          state_d = StDone;
                else if (rd_wr_q == DirRd)  state_d = StMemAcc;
                else                        state_d = StWaitDev;
            end
            StWaitDev: begin
                if (!dma_rqst) begin
                    state_d = StIdle;
                end else if (dev_ack) begin
                    din_d   = dev_out;
                    state_d = StMemAcc;
                end
            end
            StMemAcc: begin
                // The bus request is never withdrawn before the memory accepts it.
                if (dma_ready) begin
                    if (!dma_rqst)              state_d = StIdle;
                    else if (rd_wr_q == DirRd)  state_d = StMemData;
                    else                        state_d = StDevAck;
                end
            end
            StMemData: begin
                dev_in_d = dma_dout;
                if (!dma_rqst)      state_d = StIdle;
                else if (dma_resp)  state_d = StErr;
                else                state_d = StDevAck;
            end
            StDevAck: begin
                cnt_step = 1'b1;
                state_d  = StAckGap;
            end
            StAckGap: begin
                if (!dma_rqst) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    state_d = StDone;
                end else if (WORD_GAP != 0) begin
                    gap_d   = 4'd0;
                    state_d = StGap;
                end else begin
                    state_d = next_word_state(rd_wr_q, dev_ack);
                end
            end
            StGap: begin
                if (!dma_rqst) begin
                    state_d = StIdle;
                end else if (gap_q == GapLast) begin
                    state_d = next_word_state(rd_wr_q, dev_ack);
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StWaitRd: begin
                if (!dma_rqst)     state_d = StIdle;
                else if (dev_ack)  state_d = StMemAcc;
            end
            StDone, StErr: begin
                if (!dma_rqst) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rd_wr_q  <= 1'b0;
            dev_in_q <= '0;
            din_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_wr_q  <= rd_wr_d;
            dev_in_q <= dev_in_d;
            din_q    <= din_d;
            gap_q    <= gap_d;
        end
    end

    assign dev_in       = dev_in_q;
    assign dma_din      = din_q;
    assign dma_en       = (state_q == StMemAcc);
    assign dma_we       = (dma_en && rd_wr_q == DirWr) ? WeWord : WeNone;
    assign dma_priority = dma_en ? DMA_PRIORITY : 1'b0;
    assign dma_ack      = (state_q == StDevAck);
    assign dma_end_flag = (state_q == StDone) || (state_q == StErr);
    assign dma_error    = (state_q == StErr);

endmodule
